// File: rtl/tt_um_gate_tester.sv
// ---------------------------------------------------------------------------
// tt_um_gate_tester
// Stimulus/checker companion for a digital-gates tile. Sweeps the four (a,b)
// operand vectors out on uo_out[1:0], holds each for SETTLE_CYCLES, then
// compares the synchronised readback on uio_in with the expected truth table.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   ui_in    : [0] start (rising edge), [1] loop mode, [2] abort, [7:3] unused
//   uo_out   : [0] a, [1] b, [2] busy, [3] done, [4] pass, [5] fail,
//              [7:6] index of first failing vector
//   uio_in   : gates readback [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR
//              [6]~a [7]~b
//   uio_out  : tied 0
//   uio_oe   : tied 0 (all uio pins are inputs)
//
// Optional feature macro: GATE_TESTER_LOOP_EN
//   When defined, a held ui_in[1] makes DONE restart a new sweep directly;
//   the failure record stays sticky across loops.
// ---------------------------------------------------------------------------
module tt_um_gate_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Expected gate readback for vector v (a=v[0], b=v[1]).
    function automatic logic [7:0] expected_f(input logic [1:0] v);
        logic [7:0] e;
        case (v)
            2'd0:    e = 8'hF8;
            2'd1:    e = 8'h8E;
            2'd2:    e = 8'h4E;
            2'd3:    e = 8'h23;
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    state_e     state_q;
    logic [1:0] start_sync_q;
    logic       start_prev_q;
    logic [1:0] abort_sync_q;
    logic [7:0] uio_sync1_q;
    logic [7:0] uio_sync2_q;
    logic [1:0] vec_q;
    logic [7:0] ctr_q;
    logic       fail_seen_q;
    logic [1:0] first_fail_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic       fail_q;
    logic [1:0] ff_out_q;

    logic       start_s;
    logic       abort_s;
    logic       loop_s;
    logic       mismatch_s;
    logic       fail_now_s;
    logic [1:0] ff_next_s;
    logic       unused_s;

`ifdef GATE_TESTER_LOOP_EN
    logic [1:0] loop_sync_q;

    // Two-flop synchroniser for the loop-mode level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_sync_q <= 2'b00;
        end else begin
            loop_sync_q <= {loop_sync_q[0], ui_in[1]};
        end
    end

    assign loop_s   = loop_sync_q[1];
    assign unused_s = ^ui_in[7:3];
`else
    assign loop_s   = 1'b0;
    assign unused_s = ^{ui_in[7:3], ui_in[1]};
`endif

    // Two-flop synchronisers for start, abort and the gates readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= 2'b00;
            start_prev_q <= 1'b0;
            abort_sync_q <= 2'b00;
            uio_sync1_q  <= 8'h00;
            uio_sync2_q  <= 8'h00;
        end else begin
            start_sync_q <= {start_sync_q[0], ui_in[0]};
            start_prev_q <= start_sync_q[1];
            abort_sync_q <= {abort_sync_q[0], ui_in[2]};
            uio_sync1_q  <= uio_in;
            uio_sync2_q  <= uio_sync1_q;
        end
    end

    // Edge/level decode and the sample-time failure bookkeeping.
    always_comb begin
        start_s    = start_sync_q[1] & ~start_prev_q;
        abort_s    = abort_sync_q[1];
        mismatch_s = (uio_sync2_q != expected_f(vec_q));
        fail_now_s = fail_seen_q | mismatch_s;
        // An earlier failure keeps its index; otherwise this vector is first.
        if (fail_seen_q) begin
            ff_next_s = first_fail_q;
        end else begin
            ff_next_s = vec_q;
        end
    end

    // Sweep controller with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            ctr_q        <= 8'd0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 2'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            ff_out_q     <= 2'd0;
        end else if (abort_s) begin
            // Abort wins over everything, including a coincident start edge.
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            ctr_q        <= 8'd0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= 2'd0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            ff_out_q     <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q      <= ST_DRIVE;
                        vec_q        <= 2'd0;
                        fail_seen_q  <= 1'b0;
                        first_fail_q <= 2'd0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        ff_out_q     <= 2'd0;
                    end
                end
                ST_DRIVE: begin
                    a_q     <= vec_q[0];
                    b_q     <= vec_q[1];
                    ctr_q   <= 8'd0;
                    state_q <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (ctr_q == 8'(SETTLE_CYCLES - 1)) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        ctr_q <= ctr_q + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch_s && !fail_seen_q) begin
                        fail_seen_q  <= 1'b1;
                        first_fail_q <= vec_q;
                    end
                    if (vec_q == 2'd3) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pass_q   <= ~fail_now_s;
                        fail_q   <= fail_now_s;
                        ff_out_q <= fail_now_s ? ff_next_s : 2'd0;
                    end else begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    if (start_s) begin
                        state_q      <= ST_DRIVE;
                        vec_q        <= 2'd0;
                        fail_seen_q  <= 1'b0;
                        first_fail_q <= 2'd0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_q       <= 1'b0;
                        ff_out_q     <= 2'd0;
                    end else if (loop_s) begin
                        // Loop restart keeps the sticky failure record.
                        state_q  <= ST_DRIVE;
                        vec_q    <= 2'd0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        fail_q   <= 1'b0;
                        ff_out_q <= 2'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uo_out  = {ff_out_q, fail_q, pass_q, done_q, busy_q, b_q, a_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_gate_tester.sv
module tb_tt_um_gate_tester;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors_q;
    int checks_q;

    // Per-vector corruption applied by the modelled gates tile, indexed {b,a}.
    logic [7:0] fault_mask [4];

    tt_um_gate_tester dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gates tile driven by the tester's a/b outputs.
    function automatic logic [7:0] gates_f(input logic a, input logic b);
        return {~b, ~a, ~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
    endfunction

    assign uio_in = gates_f(uo_out[0], uo_out[1]) ^ fault_mask[{uo_out[1], uo_out[0]}];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            errors_q++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, time the sweep and compare against the fault-mask model.
    task automatic run_sweep(input string tag, input bit extra_start);
        bit         exp_pass;
        logic [1:0] exp_ff;
        int         n;
        bit         seen;
        bit         stable;
        exp_pass = 1'b1;
        exp_ff   = 2'd0;
        for (int v = 3; v >= 0; v--) begin
            if (fault_mask[v] != 8'h00) begin
                exp_pass = 1'b0;
                exp_ff   = 2'(v);
            end
        end
        ui_in[0] = 1'b1;
        tick();
        ui_in[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = uo_out[2];
        end
        chk({tag, "_busy_rise"}, 32'(seen), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            if (extra_start && n == 6) ui_in[0] = 1'b1;
            if (n == 7) ui_in[0] = 1'b0;
            tick();
            n++;
            seen = uo_out[3];
        end
        chk({tag, "_sweep_len"}, 32'(n), 32'd24);
        chk({tag, "_pass"}, 32'(uo_out[4]), 32'(exp_pass));
        chk({tag, "_fail"}, 32'(uo_out[5]), 32'(!exp_pass));
        chk({tag, "_ffidx"}, 32'(uo_out[7:6]), 32'(exp_ff));
        stable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (uo_out[3] !== 1'b1 || uo_out[2] !== 1'b0) stable = 1'b0;
        end
        chk({tag, "_done_hold"}, 32'(stable), 32'd1);
    endtask

    // Wait (bounded) until the given vector is on a/b during a sweep.
    task automatic wait_vec(input string tag, input logic [1:0] ab);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = (uo_out[1:0] == ab) && uo_out[2];
        end
        chk({tag, "_reach_vec"}, 32'(seen), 32'd1);
    endtask

    initial begin
        bit idle_ok;
        errors_q = 0;
        checks_q = 0;
        for (int v = 0; v < 4; v++) fault_mask[v] = 8'h00;
        ui_in = 8'h00;
        rst_n = 1'b0;
        #12;
        chk("rst_uo_out", 32'(uo_out), 32'h00);
        chk("rst_uio_oe", 32'(uio_oe), 32'h00);
        chk("rst_uio_out", 32'(uio_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (uo_out[2] !== 1'b0) idle_ok = 1'b0;
        end
        chk("idle_busy", 32'(idle_ok), 32'd1);

        // Good tile with noise on the ignored inputs.
        ui_in[7:3] = 5'b10101;
        run_sweep("good", 1'b0);

        // XOR stuck at 0 while a=0,b=1 (vector 2).
        fault_mask[2] = 8'h04;
        run_sweep("xor_fault", 1'b0);
        fault_mask[2] = 8'h00;

        // Extra start pulse mid-sweep must be ignored.
        run_sweep("start_busy", 1'b1);

        // Randomised fault patterns.
        for (int r = 0; r < 8; r++) begin
            for (int v = 0; v < 4; v++) begin
                fault_mask[v] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            end
            run_sweep($sformatf("rand%0d", r), 1'b0);
        end
        for (int v = 0; v < 4; v++) fault_mask[v] = 8'h00;

        // Abort during vector 1.
        ui_in[0] = 1'b1;
        tick();
        ui_in[0] = 1'b0;
        wait_vec("abort", 2'b01);
        ui_in[2] = 1'b1;
        tick(); tick(); tick();
        chk("abort_busy", 32'(uo_out[2]), 32'd0);
        chk("abort_done", 32'(uo_out[3]), 32'd0);
        chk("abort_ab", 32'(uo_out[1:0]), 32'd0);
        tick(); tick();
        chk("abort_hold", 32'(uo_out[5:0]), 32'd0);
        ui_in[2] = 1'b0;
        tick(); tick(); tick();
        run_sweep("post_abort", 1'b0);

        // Asynchronous reset during vector 2.
        ui_in[0] = 1'b1;
        tick();
        ui_in[0] = 1'b0;
        wait_vec("midrst", 2'b10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_uo_out", 32'(uo_out), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        run_sweep("post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors_q, checks_q);
        $finish;
    end

endmodule
